// File: rtl/fpu_req_arbiter_pkg.sv
// Shared types and constants for the FPU request arbiter: opcodes, field widths,
// controller state and the latched command record.
package fpu_ctrl_pkg;

    localparam int OP_W   = 6;
    localparam int REG_W  = 5;
    localparam int DATA_W = 32;

    localparam logic [OP_W-1:0] OP_LOAD = 6'b111110;
    localparam logic [OP_W-1:0] OP_READ = 6'b111111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef struct packed {
        logic [OP_W-1:0]   op;
        logic [REG_W-1:0]  x1;
        logic [REG_W-1:0]  x2;
        logic [REG_W-1:0]  y;
        logic [DATA_W-1:0] data;
    } fpu_cmd_t;

endpackage

// File: rtl/fpu_req_arbiter_if.sv
// Requester-side and fpu_wrapper-side signals of the arbiter. The slave modport is the
// arbiter's view; the master modport is the requesters plus the FPU.
interface fpu_req_arbiter_if #(
    parameter int N_REQ = 2
);
    import fpu_ctrl_pkg::*;

    // Requester i holds req_valid[i] and its fields until it sees req_ready[i] high in the
    // same cycle; that cycle the command is taken. On the FPU side fpu_ready is a level that
    // stays high with stable fields until fpu_valid returns, then drops for at least a cycle.
    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ-1:0]        req_ready;
    logic [N_REQ*OP_W-1:0]   req_op;
    logic [N_REQ*REG_W-1:0]  req_x1;
    logic [N_REQ*REG_W-1:0]  req_x2;
    logic [N_REQ*REG_W-1:0]  req_y;
    logic [N_REQ*DATA_W-1:0] req_data;

    logic [N_REQ-1:0]        rsp_valid;
    logic [DATA_W-1:0]       rsp_data32;
    logic                    rsp_data1;
    logic                    rsp_timeout;

    logic [OP_W-1:0]         fpu_operation;
    logic [REG_W-1:0]        fpu_x1;
    logic [REG_W-1:0]        fpu_x2;
    logic [REG_W-1:0]        fpu_y;
    logic [DATA_W-1:0]       fpu_in_data;
    logic                    fpu_ready;
    logic                    fpu_valid;
    logic                    fpu_out_data1;
    logic [DATA_W-1:0]       fpu_out_data32;

    modport slave (
        input  req_valid, req_op, req_x1, req_x2, req_y, req_data,
        input  fpu_valid, fpu_out_data1, fpu_out_data32,
        output req_ready, rsp_valid, rsp_data32, rsp_data1, rsp_timeout,
        output fpu_operation, fpu_x1, fpu_x2, fpu_y, fpu_in_data, fpu_ready
    );

    modport master (
        output req_valid, req_op, req_x1, req_x2, req_y, req_data,
        output fpu_valid, fpu_out_data1, fpu_out_data32,
        input  req_ready, rsp_valid, rsp_data32, rsp_data1, rsp_timeout,
        input  fpu_operation, fpu_x1, fpu_x2, fpu_y, fpu_in_data, fpu_ready
    );

endinterface

// File: rtl/fpu_req_arbiter_rr.sv
// Combinational round-robin picker: first asserted request strictly after ptr, wrapping,
// so the last winner has the lowest priority next time.
module rr_arbiter #(
    parameter int N_REQ = 2,
    parameter int IW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IW-1:0]    ptr,
    output logic [N_REQ-1:0] grant,
    output logic [IW-1:0]    grant_idx,
    output logic             grant_any
);

    int j;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        j         = 0;
        for (int k = 1; k <= N_REQ; k++) begin
            if (!grant_any) begin
                j = (int'(ptr) + k) % N_REQ;
                if (req[j]) begin
                    grant[j]  = 1'b1;
                    grant_idx = IW'(j);
                    grant_any = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/fpu_req_arbiter.sv
// Shares one fpu_wrapper between N_REQ requesters: round-robin accept, one op in flight,
// watchdog abort, and a one-cycle response pulse back to the owner of the op.
module fpu_req_arbiter
    import fpu_ctrl_pkg::*;
#(
    parameter int N_REQ   = 2,
    parameter int TIMEOUT = 255
) (
    input  logic               clk,
    input  logic               rst,
    fpu_req_arbiter_if.slave   bus,
    output state_t             state_dbg
);

    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

    state_t            state_q, state_d;
    fpu_cmd_t          cmd_q, cmd_sel;
    logic [IW-1:0]     ptr_q, owner_q, gnt_idx;
    logic [N_REQ-1:0]  gnt_oh;
    logic              gnt_any;
    logic [CW-1:0]     cnt_q;
    logic              timeout_hit;
    logic              accept;
    logic [N_REQ-1:0]  req_ready_c, rsp_valid_c;
    logic              fpu_ready_c;
    logic [DATA_W-1:0] rsp_data32_q;
    logic              rsp_data1_q, rsp_timeout_q;

    rr_arbiter #(.N_REQ(N_REQ), .IW(IW)) u_rr (
        .req       (bus.req_valid),
        .ptr       (ptr_q),
        .grant     (gnt_oh),
        .grant_idx (gnt_idx),
        .grant_any (gnt_any)
    );

    always_comb begin
        cmd_sel.op   = bus.req_op  [int'(gnt_idx)*OP_W   +: OP_W];
        cmd_sel.x1   = bus.req_x1  [int'(gnt_idx)*REG_W  +: REG_W];
        cmd_sel.x2   = bus.req_x2  [int'(gnt_idx)*REG_W  +: REG_W];
        cmd_sel.y    = bus.req_y   [int'(gnt_idx)*REG_W  +: REG_W];
        cmd_sel.data = bus.req_data[int'(gnt_idx)*DATA_W +: DATA_W];
    end

    assign timeout_hit = (cnt_q == TO_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (gnt_any) state_d = BUSY;
            BUSY:    if (bus.fpu_valid || timeout_hit) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // req_ready is gated by rst so an asserted reset silences the accept path at once.
    always_comb begin
        req_ready_c = '0;
        rsp_valid_c = '0;
        fpu_ready_c = 1'b0;
        accept      = 1'b0;
        case (state_q)
            IDLE: begin
                if (gnt_any && !rst) begin
                    req_ready_c = gnt_oh;
                    accept      = 1'b1;
                end
            end
            BUSY:    fpu_ready_c = 1'b1;
            RESP:    rsp_valid_c = N_REQ'(1) << owner_q;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmd_q         <= '0;
            owner_q       <= '0;
            ptr_q         <= IW'(N_REQ - 1);
            cnt_q         <= '0;
            rsp_data32_q  <= '0;
            rsp_data1_q   <= 1'b0;
            rsp_timeout_q <= 1'b0;
        end else begin
            if (accept) begin
                cmd_q   <= cmd_sel;
                owner_q <= gnt_idx;
                ptr_q   <= gnt_idx;
            end
            if (state_q == BUSY) begin
                cnt_q <= cnt_q + CW'(1);
                // A completion in the watchdog's last cycle still counts as a normal result.
                if (bus.fpu_valid) begin
                    rsp_data32_q  <= bus.fpu_out_data32;
                    rsp_data1_q   <= bus.fpu_out_data1;
                    rsp_timeout_q <= 1'b0;
                end else if (timeout_hit) begin
                    rsp_data32_q  <= '0;
                    rsp_data1_q   <= 1'b0;
                    rsp_timeout_q <= 1'b1;
                end
            end else begin
                cnt_q <= '0;
            end
        end
    end

    assign bus.req_ready     = req_ready_c;
    assign bus.rsp_valid     = rsp_valid_c;
    assign bus.rsp_data32    = rsp_data32_q;
    assign bus.rsp_data1     = rsp_data1_q;
    assign bus.rsp_timeout   = rsp_timeout_q;
    assign bus.fpu_operation = cmd_q.op;
    assign bus.fpu_x1        = cmd_q.x1;
    assign bus.fpu_x2        = cmd_q.x2;
    assign bus.fpu_y         = cmd_q.y;
    assign bus.fpu_in_data   = cmd_q.data;
    assign bus.fpu_ready     = fpu_ready_c;
    assign state_dbg         = state_q;

endmodule

// File: tb/tb_fpu_req_arbiter.sv
// Directed bench for fpu_req_arbiter with a small register-file FPU model.
module tb_fpu_req_arbiter;
  import fpu_ctrl_pkg::*;

  localparam int N  = 3;
  localparam int TO = 255;
  localparam logic [5:0] OP_MOVE = 6'b010000;

  typedef struct {
    int          r;
    logic [5:0]  op;
    logic [4:0]  x1;
    logic [4:0]  x2;
    logic [4:0]  y;
    logic [31:0] data;
    int          lat;      // FPU answer after lat ready cycles; 0 = never answers
    logic [N-1:0] exp_gnt;
    logic [31:0] exp_d32;
    logic        exp_d1;
    logic        exp_to;
  } vec_t;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fpu_req_arbiter_if #(.N_REQ(N)) bus ();
  state_t state_dbg;

  fpu_req_arbiter #(.N_REQ(N), .TIMEOUT(TO)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  int checks = 0;
  int failures = 0;

  // FPU model: a 32-entry register file answering after model_lat ready cycles
  int model_lat = 1;
  int mcnt = 0;
  logic idle_pulse = 1'b0;
  logic [31:0] mregs [0:31] = '{default: 32'h0};

  always @(negedge clk) begin
    if (bus.fpu_ready === 1'b1) begin
      mcnt = mcnt + 1;
      if (model_lat != 0 && mcnt == model_lat) begin
        bus.fpu_valid      = 1'b1;
        bus.fpu_out_data1  = (bus.fpu_operation == OP_READ);
        bus.fpu_out_data32 = (bus.fpu_operation == OP_READ) ? mregs[bus.fpu_x1] : 32'h0;
        if (bus.fpu_operation == OP_LOAD) mregs[bus.fpu_y] = bus.fpu_in_data;
        else if (bus.fpu_operation == OP_MOVE) mregs[bus.fpu_y] = mregs[bus.fpu_x1];
      end else begin
        bus.fpu_valid      = 1'b0;
        bus.fpu_out_data1  = 1'b0;
        bus.fpu_out_data32 = 32'h0;
      end
    end else begin
      mcnt = 0;
      bus.fpu_valid      = idle_pulse;
      bus.fpu_out_data1  = idle_pulse;
      bus.fpu_out_data32 = idle_pulse ? 32'hDEADBEEF : 32'h0;
    end
  end

  // scoreboard helpers
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic set_req(input int r, input logic [5:0] op, input logic [4:0] x1,
                         input logic [4:0] x2, input logic [4:0] y, input logic [31:0] data);
    bus.req_op[r*6 +: 6]     = op;
    bus.req_x1[r*5 +: 5]     = x1;
    bus.req_x2[r*5 +: 5]     = x2;
    bus.req_y[r*5 +: 5]      = y;
    bus.req_data[r*32 +: 32] = data;
  endtask

  task automatic run_vec(input vec_t v);
    bit got_gnt = 0;
    bit seen = 0;
    bit bad = 0;
    int lat_obs = 0;
    int rcnt = 0;
    int exp_lat;
    exp_lat = (v.lat == 0) ? TO + 1 : v.lat + 1;
    model_lat = v.lat;
    @(negedge clk);
    set_req(v.r, v.op, v.x1, v.x2, v.y, v.data);
    bus.req_valid = '0;
    bus.req_valid[v.r] = 1'b1;
    #1;
    for (int i = 0; i < 10; i++) begin
      if (|bus.req_ready) begin got_gnt = 1; break; end
      @(negedge clk); #1;
    end
    chk("grant", {61'h0, bus.req_ready}, {61'h0, v.exp_gnt});
    if (!got_gnt) begin
      bus.req_valid = '0;
      return;
    end
    @(negedge clk);
    bus.req_valid = '0;
    #1;
    for (int i = 1; i <= 400; i++) begin
      if (|bus.rsp_valid) begin seen = 1; lat_obs = i; break; end
      if (bus.fpu_ready === 1'b1) begin
        rcnt++;
        if ({bus.fpu_operation, bus.fpu_x1, bus.fpu_x2, bus.fpu_y, bus.fpu_in_data} !==
            {v.op, v.x1, v.x2, v.y, v.data}) bad = 1;
      end
      @(negedge clk); #1;
    end
    chk("rsp_seen", 64'(seen), 64'd1);
    chk("fields_stable", 64'(bad), 64'd0);
    chk("latency", 64'(lat_obs), 64'(exp_lat));
    chk("ready_cycles", 64'(rcnt), 64'(exp_lat - 1));
    chk("rsp_onehot", {61'h0, bus.rsp_valid}, {61'h0, v.exp_gnt});
    chk("rsp_data32", 64'(bus.rsp_data32), 64'(v.exp_d32));
    chk("rsp_data1", 64'(bus.rsp_data1), 64'(v.exp_d1));
    chk("rsp_timeout", 64'(bus.rsp_timeout), 64'(v.exp_to));
    chk("ready_low_in_resp", 64'(bus.fpu_ready), 64'd0);
    @(negedge clk); #1;
    chk("rsp_one_cycle", {61'h0, bus.rsp_valid}, 64'd0);
    chk("ready_gap", 64'(bus.fpu_ready), 64'd0);
    chk("back_idle", 64'(state_dbg), 64'(IDLE));
  endtask

  vec_t vecs [8];
  logic [N-1:0] exp_q [$];
  logic [N-1:0] rr_exp [4];

  initial begin
    bit bad;
    int grants;
    int rsps;

    vecs[0] = '{0, OP_LOAD, 5'd0, 5'd0, 5'd2, 32'hB49246D2, 3, 3'b001, 32'h0, 1'b0, 1'b0};
    vecs[1] = '{0, OP_MOVE, 5'd2, 5'd0, 5'd3, 32'h0,        1, 3'b001, 32'h0, 1'b0, 1'b0};
    vecs[2] = '{0, OP_READ, 5'd3, 5'd0, 5'd0, 32'h0,        2, 3'b001, 32'hB49246D2, 1'b1, 1'b0};
    vecs[3] = '{2, OP_LOAD, 5'd0, 5'd0, 5'd7, 32'h00000001, 5, 3'b100, 32'h0, 1'b0, 1'b0};
    vecs[4] = '{1, OP_READ, 5'd7, 5'd1, 5'd0, 32'h0,        1, 3'b010, 32'h00000001, 1'b1, 1'b0};
    vecs[5] = '{1, OP_READ, 5'd2, 5'd4, 5'd9, 32'h12345678, 4, 3'b010, 32'hB49246D2, 1'b1, 1'b0};
    vecs[6] = '{0, OP_READ, 5'd2, 5'd0, 5'd0, 32'h0,        0, 3'b001, 32'h0, 1'b0, 1'b1};
    vecs[7] = '{1, OP_READ, 5'd3, 5'd0, 5'd0, 32'h0,        2, 3'b010, 32'hB49246D2, 1'b1, 1'b0};
    rr_exp[0] = 3'b001; rr_exp[1] = 3'b010; rr_exp[2] = 3'b001; rr_exp[3] = 3'b010;

    rst = 1'b1;
    bus.req_valid = '0;
    bus.req_op = '0; bus.req_x1 = '0; bus.req_x2 = '0; bus.req_y = '0; bus.req_data = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_req_ready", {61'h0, bus.req_ready}, 64'd0);
    chk("rst_rsp_valid", {61'h0, bus.rsp_valid}, 64'd0);
    chk("rst_fpu_ready", 64'(bus.fpu_ready), 64'd0);
    chk("rst_fpu_op", 64'(bus.fpu_operation), 64'd0);
    chk("rst_rsp_data32", 64'(bus.rsp_data32), 64'd0);
    chk("rst_rsp_timeout", 64'(bus.rsp_timeout), 64'd0);
    chk("rst_state", 64'(state_dbg), 64'(IDLE));
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) run_vec(vecs[i]);

    // reset while an op from requester 0 is in flight
    model_lat = 0;
    @(negedge clk);
    set_req(0, OP_LOAD, 5'd0, 5'd0, 5'd9, 32'h5);
    bus.req_valid = 3'b001;
    #1;
    chk("mid_grant", {61'h0, bus.req_ready}, 64'd1);
    @(negedge clk);
    bus.req_valid = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("mid_busy_ready", 64'(bus.fpu_ready), 64'd1);
    @(negedge clk);
    bus.req_valid = 3'b011;
    #1;
    rst = 1'b1;
    #1;
    chk("mid_rst_fpu_ready", 64'(bus.fpu_ready), 64'd0);
    chk("mid_rst_req_ready", {61'h0, bus.req_ready}, 64'd0);
    chk("mid_rst_rsp_valid", {61'h0, bus.rsp_valid}, 64'd0);
    chk("mid_rst_state", 64'(state_dbg), 64'(IDLE));
    @(negedge clk);
    bus.req_valid = '0;
    @(negedge clk);
    rst = 1'b0;
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      if (bus.rsp_valid !== '0 || bus.fpu_ready !== 1'b0) bad = 1;
    end
    chk("post_rst_quiet", 64'(bad), 64'd0);

    // requesters 0 and 1 continuously valid right after reset
    model_lat = 1;
    set_req(0, OP_READ, 5'd3, 5'd0, 5'd0, 32'h0);
    set_req(1, OP_READ, 5'd7, 5'd0, 5'd0, 32'h0);
    grants = 0;
    rsps = 0;
    @(negedge clk);
    bus.req_valid = 3'b011;
    #1;
    for (int c = 0; c < 60 && rsps < 4; c++) begin
      if (|bus.req_ready) begin
        if (grants < 4) chk("rr_grant", {61'h0, bus.req_ready}, {61'h0, rr_exp[grants]});
        exp_q.push_back(bus.req_ready);
        grants++;
      end
      if (|bus.rsp_valid) begin
        if (exp_q.size() == 0) chk("rr_rsp_unexpected", {61'h0, bus.rsp_valid}, 64'd0);
        else chk("rr_rsp", {61'h0, bus.rsp_valid}, {61'h0, exp_q.pop_front()});
        rsps++;
      end
      @(negedge clk);
      if (grants >= 4) bus.req_valid = '0;
      #1;
    end
    chk("rr_rsp_count", 64'(rsps), 64'd4);
    chk("rr_grant_count", 64'(grants), 64'd4);

    // fpu_valid while idle must be ignored
    idle_pulse = 1'b1;
    @(negedge clk); #1;
    chk("idle_valid_state", 64'(state_dbg), 64'(IDLE));
    idle_pulse = 1'b0;
    @(negedge clk); #1;
    chk("idle_valid_no_rsp", {61'h0, bus.rsp_valid}, 64'd0);
    chk("idle_valid_state2", 64'(state_dbg), 64'(IDLE));
    chk("idle_hold_data32", 64'(bus.rsp_data32), 64'h1);
    chk("idle_hold_data1", 64'(bus.rsp_data1), 64'd1);
    chk("idle_hold_timeout", 64'(bus.rsp_timeout), 64'd0);

    // final report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL global_timeout actual=running expected=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
